// File: rtl/controlador_displays.sv
// Three-digit multiplexed 7-segment driver: converts an 8-bit value to BCD by
// sequential double-dabble and scans centenas/decenas/unidades on common-anode displays.
module controlador_displays #(
  parameter int DIV_REFRESCO = 50000,
  parameter int BLANK_CEROS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] valor,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       ocupado
);

  localparam int PW = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV_REFRESCO - 1);
  localparam bit BLANK_EN = (BLANK_CEROS != 0);

  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    CONVIERTE = 2'd1,
    ACTUALIZA = 2'd2
  } estado_t;

  estado_t       state, state_n;
  logic [7:0]    ultimo, ultimo_n, shift, shift_n;
  logic [11:0]   bcd, bcd_n;
  logic [3:0]    cnt, cnt_n;
  logic [3:0]    cen, cen_n, dec, dec_n, uni, uni_n;
  logic [PW-1:0] pre, pre_n;
  logic [1:0]    idx, idx_n;
  logic [6:0]    seg_n;
  logic [2:0]    an_n, an_sel;
  logic [3:0]    dig_sel;
  logic          blank_sel, wrap, refresh, ocupado_n;

  // One double-dabble iteration: correct nibbles >= 5, then shift {bcd,shift} left.
  function automatic logic [19:0] dabble(input logic [11:0] b, input logic [7:0] s);
    logic [11:0] a;
    a = b;
    for (int i = 0; i < 3; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        a[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end else begin
        a[4*i +: 4] = a[4*i +: 4];
      end
    end
    return {a[10:0], s, 1'b0};
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Conversion FSM next-state and datapath.
  always_comb begin
    state_n  = state;
    ultimo_n = ultimo;
    shift_n  = shift;
    bcd_n    = bcd;
    cnt_n    = cnt;
    cen_n    = cen;
    dec_n    = dec;
    uni_n    = uni;
    case (state)
      ESPERA: begin
        if (valor != ultimo) begin
          shift_n  = valor;
          ultimo_n = valor;
          bcd_n    = 12'd0;
          cnt_n    = 4'd0;
          state_n  = CONVIERTE;
        end else begin
          state_n  = ESPERA;
        end
      end
      CONVIERTE: begin
        {bcd_n, shift_n} = dabble(bcd, shift);
        cnt_n = cnt + 4'd1;
        if (cnt == 4'd7) begin
          state_n = ACTUALIZA;
        end else begin
          state_n = CONVIERTE;
        end
      end
      ACTUALIZA: begin
        cen_n   = bcd[11:8];
        dec_n   = bcd[7:4];
        uni_n   = bcd[3:0];
        state_n = ESPERA;
      end
      default: state_n = ESPERA;
    endcase
    ocupado_n = (state_n != ESPERA);
  end

  // Scan prescaler, digit select and blanking; seg/an refresh only on wrap or digit update.
  always_comb begin
    wrap    = (pre == PRE_MAX);
    refresh = wrap || (state == ACTUALIZA);
    if (wrap) begin
      pre_n = {PW{1'b0}};
      idx_n = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      pre_n = pre + PW'(1);
      idx_n = idx;
    end
    case (idx_n)
      2'd0: begin
        an_sel = 3'b110; dig_sel = uni_n; blank_sel = 1'b0;
      end
      2'd1: begin
        an_sel = 3'b101; dig_sel = dec_n;
        blank_sel = BLANK_EN && (cen_n == 4'd0) && (dec_n == 4'd0);
      end
      2'd2: begin
        an_sel = 3'b011; dig_sel = cen_n;
        blank_sel = BLANK_EN && (cen_n == 4'd0);
      end
      default: begin
        an_sel = 3'b110; dig_sel = uni_n; blank_sel = 1'b0;
      end
    endcase
    if (refresh) begin
      seg_n = blank_sel ? 7'b1111111 : encode(dig_sel);
      an_n  = an_sel;
    end else begin
      seg_n = seg;
      an_n  = an;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ESPERA;
      ultimo  <= 8'd0;
      shift   <= 8'd0;
      bcd     <= 12'd0;
      cnt     <= 4'd0;
      cen     <= 4'd0;
      dec     <= 4'd0;
      uni     <= 4'd0;
      pre     <= {PW{1'b0}};
      idx     <= 2'd0;
      an      <= 3'b110;
      seg     <= 7'b1000000;
      ocupado <= 1'b0;
    end else begin
      state   <= state_n;
      ultimo  <= ultimo_n;
      shift   <= shift_n;
      bcd     <= bcd_n;
      cnt     <= cnt_n;
      cen     <= cen_n;
      dec     <= dec_n;
      uni     <= uni_n;
      pre     <= pre_n;
      idx     <= idx_n;
      an      <= an_n;
      seg     <= seg_n;
      ocupado <= ocupado_n;
    end
  end

endmodule

// File: doc/controlador_displays.md
CONTROLADOR_DISPLAYS -- requirements
Module: controlador_displays

Interface
REQ-001 SHALL have parameter DIV_REFRESCO, default 50000, meaning clock cycles each digit stays lit (1 kHz per digit at 50 MHz).
REQ-002 SHALL have parameter BLANK_CEROS, default 1, meaning 1 blanks leading zeros and 0 shows all three digits.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all flops on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port valor, input, 8 bits: unsigned result from the upstream math-function stage (0..255).
REQ-006 SHALL have port seg, output, 7 bits: {g,f,e,d,c,b,a}, active-low (common anode).
REQ-007 SHALL have port an, output, 3 bits: digit enables, active-low; an[0]=unidades, an[1]=decenas, an[2]=centenas.
REQ-008 SHALL have port ocupado, output, 1 bit: high while the FSM is not in ESPERA.

Function
REQ-009 SHALL hold registers: ultimo[7:0] (last converted value), shift[7:0], bcd[11:0], cnt[3:0], cen/dec/uni[3:0] (displayed digits).
REQ-010 SHALL implement FSM states ESPERA, CONVIERTE and ACTUALIZA.
REQ-011 In ESPERA, when valor != ultimo, SHALL load shift<=valor, ultimo<=valor, bcd<=0 and cnt<=0, then go to CONVIERTE; otherwise SHALL stay in ESPERA.
REQ-012 In CONVIERTE, each cycle SHALL add 3 to every bcd nibble >=5, then shift {bcd,shift} left 1 bit and increment cnt.
REQ-013 CONVIERTE SHALL perform exactly 8 iterations, then go to ACTUALIZA.
REQ-014 ACTUALIZA SHALL copy bcd[11:8]->cen, bcd[7:4]->dec and bcd[3:0]->uni, then return to ESPERA.
REQ-015 Latency SHALL be 10 rising edges from the capturing edge in ESPERA to new cen/dec/uni (1 capture + 8 shift + 1 update).
REQ-016 A valor change while in CONVIERTE/ACTUALIZA SHALL NOT affect the running conversion; it SHALL be detected on return to ESPERA.
REQ-017 Displayed digits SHALL never show a partial conversion result.
REQ-018 A prescaler SHALL count 0..DIV_REFRESCO-1 and wrap to 0; on wrap the digit index SHALL advance 0->1->2->0.
REQ-019 Digit index 0 SHALL drive an=3'b110 with uni; index 1 SHALL drive an=3'b101 with dec; index 2 SHALL drive an=3'b011 with cen.
REQ-020 seg/an SHALL be registered and SHALL change only on the prescaler-wrap edge or when cen/dec/uni update.
REQ-021 Digit encoding SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other code SHALL give 1111111.
REQ-022 With BLANK_CEROS=1, centenas SHALL be blank (seg=1111111) when cen==0, and decenas SHALL be blank when cen==0 and dec==0.
REQ-023 The unidades digit SHALL never be blanked.
REQ-024 Blanked digits SHALL still have their an enable asserted, to keep a constant scan duty cycle.
REQ-025 ocupado SHALL be high from the edge after capture until the edge that returns the FSM to ESPERA.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) force: state=ESPERA, ultimo/shift/bcd/cnt/cen/dec/uni=0, prescaler=0, digit index=0, an=3'b110, seg=7'b1000000, ocupado=0.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion, with no digit update.
REQ-028 After release, a nonzero valor SHALL be captured on the first rising edge.

Verification (DIV_REFRESCO=4)
REQ-029 Reset, valor=0, release -> an=110, seg=1000000, ocupado=0 indefinitely; no conversion started.
REQ-030 valor=225 -> ocupado high 9 cycles; after 10 edges cen/dec/uni=2/2/5; scan shows uni=0010010, dec=0100100, cen=0100100.
REQ-031 valor=32, BLANK_CEROS=1 -> an=011 gives seg=1111111, an=101 gives 0110000, an=110 gives 0100100; with BLANK_CEROS=0, an=011 gives 1000000.
REQ-032 valor=225, then 7 at the 3rd CONVIERTE cycle -> digits first 2/2/5, then second conversion; final display shows 7 with centenas and decenas blank.
REQ-033 Scan check -> an sequence 110,101,011,110 with each step lasting exactly 4 cycles; prescaler wraps at 3.
REQ-034 rst_n pulse low mid-CONVIERTE (valor=144) -> outputs at reset values without a clock edge; after release, 144 reconverted and shown 1/4/4 10 edges later.
